// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one BCD digit slice reused LSD-first, one digit per clock.
// Optional macro BCD_DIGIT_CHECK_EN builds the sticky invalid-digit flag on err.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  c_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  c_out,
    output logic                  err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_nxt;
    logic                    accept_c;
    logic [CNT_W-1:0]        cnt_q;
    logic                    carry_q;
    logic [DIGITS-1:0][3:0]  a_q, b_q, res_q;

    logic [3:0]              a_d_c, b_d_c, dig_c;
    logic [4:0]              t_c;
    logic                    cy_c;
    logic [DIGITS-1:0][3:0]  res_c;

    // Shared digit slice: select current digits, BCD-correct, merge into the result.
    always_comb begin
        a_d_c = '0;
        b_d_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_d_c = a_q[i];
                b_d_c = b_q[i];
            end
        end
        t_c = 5'(a_d_c) + 5'(b_d_c) + 5'(carry_q);
        if (t_c > 5'd9) begin
            dig_c = 4'(t_c + 5'd6);
            cy_c  = 1'b1;
        end else begin
            dig_c = t_c[3:0];
            cy_c  = 1'b0;
        end
        res_c = res_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                res_c[i] = dig_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (cnt_q == LAST_CNT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = S_ADD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, digit stepping, and result publication on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= c_in;
                cnt_q   <= '0;
                res_q   <= '0;
            end else if (state_q == S_ADD) begin
                res_q   <= res_c;
                carry_q <= cy_c;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum   <= res_c;
                    c_out <= cy_c;
                end
            end
            ready <= (state_nxt != S_ADD);
            busy  <= (state_nxt == S_ADD);
            done  <= (state_nxt == S_DONE);
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic inv_c;
    assign inv_c = (a_d_c > 4'd9) || (b_d_c > 4'd9);

    // Sticky until the next accepted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept_c) begin
            err <= 1'b0;
        end else if ((state_q == S_ADD) && inv_c) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
